ulpb_tx_arbiter: RTL and testbench

Round-robin transmit arbiter that shares one ulpb_node transmit port among NUM_REQ local requesters. It sits between on-chip message sources and the node's ADDR_IN/DATA_IN/REQ_TX/ACK_TX interface. It selects one requester, presents its address and payload to the node, and runs the node's four-phase REQ_TX/ACK_TX handshake. It then completes a matching four-phase handshake back to the winning requester.

---
 rtl/ulpb_tx_arbiter_if.sv | 31 +++
 rtl/ulpb_tx_arbiter.sv | 136 +++++++++++++
 tb/tb_ulpb_tx_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ulpb_tx_arbiter_if.sv
// Signal bundle between the transmit arbiter, its local requesters and the ulpb_node transmit port.
// The arbiter connects through the master modport; the environment uses the slave modport.
interface ulpb_tx_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]            REQ_IN;
  logic [NUM_REQ*ADDR_WIDTH-1:0] ADDR_IN;
  logic [NUM_REQ*DATA_WIDTH-1:0] DATA_IN;
  logic [NUM_REQ-1:0]            ACK_OUT;
  logic [ADDR_WIDTH-1:0]         ADDR_TX;
  logic [DATA_WIDTH-1:0]         DATA_TX;
  logic                          REQ_TX;
  logic                          ACK_TX;
  logic [ID_W-1:0]               GRANT_ID;
  logic                          BUSY;
  logic [15:0]                   TX_COUNT;

  modport master (
    input  REQ_IN, ADDR_IN, DATA_IN, ACK_TX,
    output ACK_OUT, ADDR_TX, DATA_TX, REQ_TX, GRANT_ID, BUSY, TX_COUNT
  );

  modport slave (
    output REQ_IN, ADDR_IN, DATA_IN, ACK_TX,
    input  ACK_OUT, ADDR_TX, DATA_TX, REQ_TX, GRANT_ID, BUSY, TX_COUNT
  );
endinterface

// File: rtl/ulpb_tx_arbiter.sv
// Round-robin arbiter sharing one ulpb_node transmit port among NUM_REQ requesters,
// running four-phase handshakes towards the node and back to the winning requester.
module ulpb_tx_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                 CLK,
  input  logic                 RESET,
  ulpb_tx_arbiter_if.master    bus
);
  localparam int ID_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, WAIT_ACK, WAIT_REL, DONE} state_t;

  state_t                state_q, state_d;
  logic [ID_W-1:0]       ptr_q, ptr_d;
  logic [ID_W-1:0]       grant_q, grant_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  req_tx_q, req_tx_d;
  logic [NUM_REQ-1:0]    ack_q, ack_d;
  logic [15:0]           cnt_q, cnt_d;
  logic                  busy_q;
  logic [ID_W-1:0]       winner;

  logic [ADDR_WIDTH-1:0] addr_arr [NUM_REQ];
  logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];

  // Index increment that wraps at NUM_REQ, which need not be a power of two.
  function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] v);
    return (v == ID_W'(NUM_REQ - 1)) ? '0 : v + ID_W'(1);
  endfunction

  function automatic logic [ID_W-1:0] pick_winner(input logic [NUM_REQ-1:0] req,
                                                  input logic [ID_W-1:0]    ptr);
    logic [ID_W-1:0] idx;
    logic [ID_W-1:0] win;
    logic            found;
    idx   = ptr;
    win   = ptr;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
      idx = wrap_inc(idx);
    end
    return win;
  endfunction

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_arr[g] = bus.ADDR_IN[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign data_arr[g] = bus.DATA_IN[g*DATA_WIDTH +: DATA_WIDTH];
  end

  assign winner = pick_winner(bus.REQ_IN, ptr_q);

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    grant_d  = grant_q;
    addr_d   = addr_q;
    data_d   = data_q;
    req_tx_d = req_tx_q;
    ack_d    = ack_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (|bus.REQ_IN) begin
          grant_d  = winner;
          addr_d   = addr_arr[winner];
          data_d   = data_arr[winner];
          req_tx_d = 1'b1;
          state_d  = WAIT_ACK;
        end
      end
      // No timeout: a lost bus arbitration keeps REQ_TX up while the node retries.
      WAIT_ACK: begin
        if (bus.ACK_TX) begin
          req_tx_d = 1'b0;
          state_d  = WAIT_REL;
        end
      end
      WAIT_REL: begin
        if (!bus.ACK_TX) begin
          ack_d   = NUM_REQ'(1) << grant_q;
          cnt_d   = cnt_q + 16'd1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (!bus.REQ_IN[grant_q]) begin
          ack_d   = '0;
          ptr_d   = wrap_inc(grant_q);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      grant_q  <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      req_tx_q <= 1'b0;
      ack_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      grant_q  <= grant_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      req_tx_q <= req_tx_d;
      ack_q    <= ack_d;
      cnt_q    <= cnt_d;
      busy_q   <= (state_d != IDLE);
    end
  end

  assign bus.ACK_OUT  = ack_q;
  assign bus.ADDR_TX  = addr_q;
  assign bus.DATA_TX  = data_q;
  assign bus.REQ_TX   = req_tx_q;
  assign bus.GRANT_ID = grant_q;
  assign bus.BUSY     = busy_q;
  assign bus.TX_COUNT = cnt_q;

endmodule

// File: tb/tb_ulpb_tx_arbiter.sv
// Scoreboard bench for ulpb_tx_arbiter: a requester/node driver feeds a round-robin reference
// model whose predicted grants are queued and checked by an independent output monitor.
module tb_ulpb_tx_arbiter;
  localparam int NUM_REQ    = 4;
  localparam int ADDR_WIDTH = 8;
  localparam int DATA_WIDTH = 32;

  logic CLK   = 1'b0;
  logic RESET = 1'b1;
  always #5 CLK = ~CLK;

  ulpb_tx_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) bus ();

  ulpb_tx_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  typedef struct {
    int                    id;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
    int unsigned           cyc;
  } grant_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  int unsigned cyc      = 0;
  bit          aborted  = 1'b0;

  grant_t exp_q[$];
  int     grant_log[$];

  // Reference model state: requester levels/payloads and the round-robin pointer.
  logic [NUM_REQ-1:0]    req_lv;
  logic [ADDR_WIDTH-1:0] req_addr [NUM_REQ];
  logic [DATA_WIDTH-1:0] req_data [NUM_REQ];
  int                    rr_ptr;

  int node_ack_delay = -1;
  int node_rel_delay = -1;
  int nst, ncnt;

  int          mon_phase = 0;
  grant_t      cur;
  logic [15:0] exp_cnt;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_fail++;
    aborted = 1'b1;
    $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
  endtask

  function automatic int model_pick(input logic [NUM_REQ-1:0] pend, input int ptr);
    for (int k = 0; k < NUM_REQ; k++)
      if (pend[(ptr + k) % NUM_REQ]) return (ptr + k) % NUM_REQ;
    return -1;
  endfunction

  function automatic int last_grant();
    if (grant_log.size() == 0) return -1;
    return grant_log[grant_log.size() - 1];
  endfunction

  task automatic apply_inputs();
    bus.REQ_IN = req_lv;
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.ADDR_IN[i*ADDR_WIDTH +: ADDR_WIDTH] = req_addr[i];
      bus.DATA_IN[i*DATA_WIDTH +: DATA_WIDTH] = req_data[i];
    end
  endtask

  task automatic set_req(input int i, input logic [ADDR_WIDTH-1:0] a, input logic [DATA_WIDTH-1:0] d);
    req_lv[i]   = 1'b1;
    req_addr[i] = a;
    req_data[i] = d;
    apply_inputs();
  endtask

  task automatic predict();
    grant_t g;
    int     win;
    win = model_pick(req_lv, rr_ptr);
    if (win < 0) return;
    g.id   = win;
    g.addr = req_addr[win];
    g.data = req_data[win];
    g.cyc  = cyc;
    exp_q.push_back(g);
    rr_ptr = (win + 1) % NUM_REQ;
  endtask

  // Called on a falling edge while the arbiter is idle.
  task automatic do_round(input logic [NUM_REQ-1:0] add_mask, input int rel_hold);
    int t;
    if (aborted) return;
    for (int i = 0; i < NUM_REQ; i++)
      if (add_mask[i] && !req_lv[i]) set_req(i, ADDR_WIDTH'($urandom), DATA_WIDTH'($urandom));
    if (req_lv == '0) return;
    predict();
    t = 0;
    while (bus.ACK_OUT == '0) begin
      @(negedge CLK);
      t++;
      if (t > 2000) begin timeout_fail("ack_out_timeout"); return; end
    end
    repeat (rel_hold) @(negedge CLK);
    req_lv = req_lv & ~bus.ACK_OUT;
    apply_inputs();
    t = 0;
    do begin @(negedge CLK); t++; end while (bus.BUSY && t < 50);
    if (bus.BUSY) timeout_fail("busy_release_timeout");
  endtask

  task automatic do_reset();
    #2 RESET = 1'b0;
    #1;
    check("rst_async_req_tx", bus.REQ_TX, 0);
    check("rst_async_ack_out", bus.ACK_OUT, 0);
    check("rst_async_tx_count", bus.TX_COUNT, 0);
    check("rst_async_busy", bus.BUSY, 0);
    check("rst_async_grant_id", bus.GRANT_ID, 0);
    check("rst_async_addr_tx", bus.ADDR_TX, 0);
    check("rst_async_data_tx", bus.DATA_TX, 0);
    req_lv = '0;
    apply_inputs();
    rr_ptr = 0;
    exp_q.delete();
    repeat (3) @(negedge CLK);
    RESET = 1'b1;
  endtask

  // Node model: acknowledges REQ_TX after a delay and releases after REQ_TX drops.
  initial begin
    bus.ACK_TX = 1'b0;
    nst = 0;
    ncnt = 0;
    forever begin
      @(negedge CLK);
      if (!RESET) begin
        bus.ACK_TX = 1'b0;
        nst = 0;
      end else begin
        case (nst)
          0: if (bus.REQ_TX) begin
               ncnt = (node_ack_delay < 0) ? int'($urandom_range(0, 4)) : node_ack_delay;
               nst = 1;
             end
          1: if (ncnt == 0) begin bus.ACK_TX = 1'b1; nst = 2; end else ncnt--;
          2: if (!bus.REQ_TX) begin
               ncnt = (node_rel_delay < 0) ? int'($urandom_range(0, 3)) : node_rel_delay;
               nst = 3;
             end
          default: if (ncnt == 0) begin bus.ACK_TX = 1'b0; nst = 0; end else ncnt--;
        endcase
      end
    end
  end

  // Output monitor: pops predicted grants and follows the handshake phases.
  initial begin
    exp_cnt = '0;
    forever begin
      @(posedge CLK);
      #1;
      if (!RESET) begin
        mon_phase = 0;
        exp_cnt   = '0;
        check("rst_outputs", {bus.REQ_TX, bus.ACK_OUT, bus.BUSY, bus.TX_COUNT}, 0);
      end else begin
        if (mon_phase == 1 || mon_phase == 2 || (mon_phase == 3 && bus.REQ_IN[cur.id])) begin
          check("hold_grant_id", bus.GRANT_ID, cur.id);
          check("hold_addr_tx", bus.ADDR_TX, cur.addr);
          check("hold_data_tx", bus.DATA_TX, cur.data);
        end
        case (mon_phase)
          0: begin
            if (bus.REQ_TX) begin
              if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_grant: grant %0d with nothing predicted (cycle %0d)", bus.GRANT_ID, cyc);
                mon_phase = 4;
              end else begin
                cur = exp_q.pop_front();
                grant_log.push_back(int'(bus.GRANT_ID));
                check("grant_id", bus.GRANT_ID, cur.id);
                check("grant_addr_tx", bus.ADDR_TX, cur.addr);
                check("grant_data_tx", bus.DATA_TX, cur.data);
                check("grant_latency", cyc - cur.cyc, 1);
                check("grant_busy", bus.BUSY, 1);
                mon_phase = 1;
              end
            end else begin
              check("idle_outputs", {bus.BUSY, bus.ACK_OUT}, 0);
            end
          end
          1: begin
            check("wait_ack_ack_out", bus.ACK_OUT, 0);
            if (bus.ACK_TX) begin
              check("req_tx_drop", bus.REQ_TX, 0);
              mon_phase = 2;
            end else begin
              check("req_tx_hold", bus.REQ_TX, 1);
            end
          end
          2: begin
            check("wait_rel_req_tx", bus.REQ_TX, 0);
            if (!bus.ACK_TX) begin
              exp_cnt = exp_cnt + 16'd1;
              check("ack_out_set", bus.ACK_OUT, 64'(1) << cur.id);
              check("tx_count", bus.TX_COUNT, exp_cnt);
              mon_phase = 3;
            end else begin
              check("wait_rel_ack_out", bus.ACK_OUT, 0);
            end
          end
          3: begin
            if (!bus.REQ_IN[cur.id]) begin
              check("done_exit", {bus.BUSY, bus.ACK_OUT}, 0);
              mon_phase = 0;
            end else begin
              check("done_hold", {bus.REQ_TX, bus.BUSY, bus.ACK_OUT}, {1'b0, 1'b1, NUM_REQ'(1) << cur.id});
            end
          end
          default: if (!bus.BUSY) mon_phase = 0;
        endcase
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int t;
    int rr_exp [5];
    rr_exp = '{0, 1, 2, 3, 0};
    req_lv = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_addr[i] = '0;
      req_data[i] = '0;
    end
    apply_inputs();
    rr_ptr = 0;

    do_reset();

    // Single requester, node acknowledges after 10 cycles.
    node_ack_delay = 10;
    set_req(2, 8'h5a, 32'hdeadbeef);
    do_round('0, 0);
    node_ack_delay = -1;
    check("single_grant", last_grant(), 2);
    check("single_tx_count", bus.TX_COUNT, 1);

    // Round-robin from a fresh pointer with all four requesting.
    do_reset();
    base = grant_log.size();
    for (int r = 0; r < 5; r++) do_round(4'b1111, 0);
    check("rr_log_len", grant_log.size() - base, 5);
    if (grant_log.size() - base >= 5)
      for (int r = 0; r < 5; r++) check("rr_order", grant_log[base + r], rr_exp[r]);
    check("rr_tx_count", bus.TX_COUNT, 5);
    for (int r = 0; r < 4; r++) do_round('0, 0);

    // Pointer skip: serve 1, then 0 and 1 together must give 0 first.
    do_round(4'b0010, 0);
    do_round(4'b0011, 0);
    check("skip_first", last_grant(), 0);
    do_round('0, 0);
    check("skip_second", last_grant(), 1);

    // Lost arbitration: node withholds ACK_TX for 200 cycles.
    node_ack_delay = 200;
    do_round(4'b0100, 0);
    node_ack_delay = -1;
    check("lost_arb_grant", last_grant(), 2);

    // Slow release of requester 3 with requester 0 waiting.
    do_round(4'b1001, 5);
    check("slow_rel_grant", last_grant(), 3);
    do_round('0, 0);
    check("slow_rel_next", last_grant(), 0);

    for (int r = 0; r < 40; r++) do_round(NUM_REQ'($urandom_range(0, 15)), int'($urandom_range(0, 3)));
    for (int r = 0; r < NUM_REQ; r++) do_round('0, 0);

    // Reset while the arbiter waits for the node to release ACK_TX.
    if (!aborted) begin
      node_rel_delay = 30;
      set_req(1, ADDR_WIDTH'($urandom), DATA_WIDTH'($urandom));
      predict();
      t = 0;
      do begin @(negedge CLK); t++; end while (!(bus.ACK_TX && !bus.REQ_TX && bus.BUSY) && t < 100);
      if (t >= 100) timeout_fail("wait_rel_timeout");
      repeat (2) @(negedge CLK);
      do_reset();
      node_rel_delay = -1;
      do_round(4'b1000, 0);
      check("post_reset_grant", last_grant(), 3);
      check("post_reset_tx_count", bus.TX_COUNT, 1);
      do_round(4'b0110, 1);
      check("post_reset_next", last_grant(), 1);
      do_round('0, 0);
    end

    repeat (3) @(negedge CLK);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
